// File: rtl/netdly_tapline_ctl_pkg.sv
// Shared definitions for the DELAYF-compatible tap-line responder and its controller.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package netdly_tapline_ctl_pkg;

   // DIRECTION encoding shared with the network delay controller.
   localparam logic DLY_DOWN = 1'b1;
   localparam logic DLY_UP   = 1'b0;

   // Bits needed to hold values 0 .. value-1; used to size and check the tap counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/netdly_tapline_ctl_if.sv
// DELAYF control handshake between the delay controller (master) and the tap line (slave).
// Latency: n/a (wiring only). Backpressure: none; MOVE is edge-based, CFLAG reports the limit.
// Signals: i_loadn, i_move, i_direction (controller -> tap line); o_cflag, o_tap (tap line -> controller).
interface netdly_tapline_ctl_if #(
   parameter int TAPW = 7
);
   logic            i_loadn;
   logic            i_move;
   logic            i_direction;
   logic            o_cflag;
   logic [TAPW-1:0] o_tap;

   modport master (
      output i_loadn, i_move, i_direction,
      input  o_cflag, o_tap
   );

   modport slave (
      input  i_loadn, i_move, i_direction,
      output o_cflag, o_tap
   );
endinterface

// File: rtl/netdly_lane.sv
// One data lane of the tap line: a MAXTAP+1 stage shift register with a tap-selected output register.
// Latency: i_pin to o_pin is i_tap + 2 cycles.
// Backpressure: none; the lane shifts every clock.
// Ports: i_clk, i_reset_n (async, active-low), i_tap (shared tap count), i_pin (lane in), o_pin (lane out).
module netdly_lane
   import netdly_tapline_ctl_pkg::*;
#(
   parameter int MAXTAP = 127,
   parameter int TAPW   = 7
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [TAPW-1:0] i_tap,
   input  logic            i_pin,
   output logic            o_pin
);

   logic [MAXTAP:0] sr_q;
   logic            pin_d;
   logic            pin_q;

   // Explicit compare mux keeps the select in range even when 2**TAPW exceeds MAXTAP+1.
   always_comb begin
      pin_d = 1'b0;
      for (int j = 0; j <= MAXTAP; j++) begin
         if (i_tap == TAPW'(j)) begin
            pin_d = sr_q[j];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sr_q  <= '0;
         pin_q <= 1'b0;
      end else begin
         sr_q  <= {sr_q[MAXTAP-1:0], i_pin};
         pin_q <= pin_d;
      end
   end

   assign o_pin = pin_q;

endmodule

// File: rtl/netdly_tapline_ctl.sv
// Simulation/non-ECP5 stand-in for the per-pin DELAYF: shared tap counter driving NP whole-cycle delay lanes.
// Latency: tap updates one cycle after a MOVE rising edge; i_pin to o_pin is tap + 2 cycles.
// Backpressure: none; steps at a limit are dropped silently and flagged on o_cflag.
// Ports: i_clk, i_reset_n (async, active-low), ctl (slave: loadn/move/direction in, cflag/tap out),
//        i_pin[NP] lane inputs, o_pin[NP] delayed lane outputs.
module netdly_tapline_ctl
   import netdly_tapline_ctl_pkg::*;
#(
   parameter int NP          = 4,
   parameter int TAPW        = 7,
   parameter int MAXTAP      = 127,
   parameter int DEFAULT_TAP = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   netdly_tapline_ctl_if.slave  ctl,
   input  logic [NP-1:0]        i_pin,
   output logic [NP-1:0]        o_pin
);

   if (TAPW < clog2(MAXTAP + 1)) begin : g_bad_tapw
      $error("netdly_tapline_ctl: MAXTAP does not fit in TAPW bits");
   end
   if (DEFAULT_TAP > MAXTAP) begin : g_bad_default
      $error("netdly_tapline_ctl: DEFAULT_TAP exceeds MAXTAP");
   end

   localparam logic [TAPW-1:0] MAX_T = TAPW'(MAXTAP);
   localparam logic [TAPW-1:0] DEF_T = TAPW'(DEFAULT_TAP);

   logic [TAPW-1:0] tap_q;
   logic [TAPW-1:0] tap_d;
   logic            move_q;
   logic            step;

   // move_q resets high so a MOVE already asserted at reset release is not seen as an edge.
   assign step = ctl.i_move & ~move_q;

   // LOADN wins over any step in the same cycle; steps at a limit saturate.
   always_comb begin
      tap_d = tap_q;
      if (!ctl.i_loadn) begin
         tap_d = DEF_T;
      end else if (step && (ctl.i_direction == DLY_DOWN) && (tap_q != '0)) begin
         tap_d = tap_q - TAPW'(1);
      end else if (step && (ctl.i_direction == DLY_UP) && (tap_q != MAX_T)) begin
         tap_d = tap_q + TAPW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tap_q  <= DEF_T;
         move_q <= 1'b1;
      end else begin
         tap_q  <= tap_d;
         move_q <= ctl.i_move;
      end
   end

   // Combinational on purpose: the controller reads CFLAG while DIRECTION is held stable.
   assign ctl.o_cflag = (ctl.i_direction == DLY_DOWN) ? (tap_q == '0) : (tap_q == MAX_T);
   assign ctl.o_tap   = tap_q;

   for (genvar k = 0; k < NP; k++) begin : g_lane
      netdly_lane #(
         .MAXTAP (MAXTAP),
         .TAPW   (TAPW)
      ) u_lane (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_tap     (tap_q),
         .i_pin     (i_pin[k]),
         .o_pin     (o_pin[k])
      );
   end

endmodule

// File: tb/tb_netdly_tapline_ctl.sv
// Bench for netdly_tapline_ctl: two builds (MAXTAP=127/TAPW=7 and MAXTAP=7/TAPW=3) driven in parallel.
// Expected values come from a saturating tap model and a per-cycle input history indexed by age.
// Directed scenarios first, then randomized MOVE/DIRECTION/LOADN/pin traffic with occasional async resets.
module tb_netdly_tapline_ctl;
   import netdly_tapline_ctl_pkg::*;

   localparam int NP    = 4;
   localparam int MAXA  = 127;
   localparam int TAPWA = 7;
   localparam int MAXB  = 7;
   localparam int TAPWB = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          loadn;
   logic          move;
   logic          dir;
   logic [NP-1:0] pin;
   logic [NP-1:0] pin_a;
   logic [NP-1:0] pin_b;

   always #5 clk = ~clk;

   netdly_tapline_ctl_if #(.TAPW(TAPWA)) ifa ();
   netdly_tapline_ctl_if #(.TAPW(TAPWB)) ifb ();

   assign ifa.i_loadn     = loadn;
   assign ifa.i_move      = move;
   assign ifa.i_direction = dir;
   assign ifb.i_loadn     = loadn;
   assign ifb.i_move      = move;
   assign ifb.i_direction = dir;

   netdly_tapline_ctl #(.NP(NP), .TAPW(TAPWA), .MAXTAP(MAXA), .DEFAULT_TAP(0)) u_dut_a (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .ctl       (ifa),
      .i_pin     (pin),
      .o_pin     (pin_a)
   );

   netdly_tapline_ctl #(.NP(NP), .TAPW(TAPWB), .MAXTAP(MAXB), .DEFAULT_TAP(0)) u_dut_b (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .ctl       (ifb),
      .i_pin     (pin),
      .o_pin     (pin_b)
   );

   int n_chk;
   int n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_max [2] = '{MAXA, MAXB};
   int            m_tap [2];
   bit            m_mq;
   logic [NP-1:0] m_out [2];
   logic [NP-1:0] m_hist [$];   // index = age in cycles, 0 = most recently captured input

   function automatic logic [NP-1:0] aged(input int a);
      return (a < m_hist.size()) ? m_hist[a] : '0;
   endfunction

   function automatic logic exp_cflag(input int i);
      return dir ? (m_tap[i] == 0) : (m_tap[i] == m_max[i]);
   endfunction

   task automatic model_reset();
      m_tap[0] = 0;
      m_tap[1] = 0;
      m_mq     = 1'b1;
      m_hist.delete();
      m_out[0] = '0;
      m_out[1] = '0;
   endtask

   task automatic model_edge();
      bit step;
      step = move && !m_mq;
      for (int i = 0; i < 2; i++) begin
         // Output takes the sample whose age equals the tap in force before this edge.
         m_out[i] = aged(m_tap[i]);
         if (!loadn) begin
            m_tap[i] = 0;
         end else if (step && dir) begin
            if (m_tap[i] > 0) m_tap[i] = m_tap[i] - 1;
         end else if (step && !dir) begin
            if (m_tap[i] < m_max[i]) m_tap[i] = m_tap[i] + 1;
         end
      end
      m_mq = move;
      m_hist.push_front(pin);
      if (m_hist.size() > MAXA + 1) void'(m_hist.pop_back());
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/tapA"},   32'(ifa.o_tap),   32'(m_tap[0]));
      chk({tag, "/tapB"},   32'(ifb.o_tap),   32'(m_tap[1]));
      chk({tag, "/cflagA"}, 32'(ifa.o_cflag), 32'(exp_cflag(0)));
      chk({tag, "/cflagB"}, 32'(ifb.o_cflag), 32'(exp_cflag(1)));
      chk({tag, "/pinA"},   32'(pin_a),       32'(m_out[0]));
      chk({tag, "/pinB"},   32'(pin_b),       32'(m_out[1]));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int p = 0; p < n; p++) begin
         move = 1'b1;
         repeat (hi) tick("move_hi");
         move = 1'b0;
         repeat (lo) tick("move_lo");
      end
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      loadn = 1'b1;
      move  = 1'b0;
      dir   = DLY_DOWN;
      pin   = '0;
      model_reset();

      // Reset state.
      #12;
      chk("rst_tap",   32'(ifa.o_tap),   32'd0);
      chk("rst_cflag", 32'(ifa.o_cflag), 32'd1);
      chk("rst_pin",   32'(pin_a),       32'd0);
      dir = DLY_UP;
      #1;
      chk("cflag_follows_dir", 32'(ifa.o_cflag), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick("idle");

      // Five wide UP pulses, then a single-cycle pulse on lane 0 at tap 5.
      pulses(5, 3, 3);
      chk("five_up_tapA", 32'(ifa.o_tap), 32'd5);
      pin = 4'b0001;
      tick("pin_capture");
      pin = '0;
      for (int k = 2; k <= 9; k++) begin
         tick("pin_walk");
         chk("lane0_lat7",  32'(pin_a[0]),   32'(k == 7));
         chk("lanes_quiet", 32'(pin_a[3:1]), 32'd0);
      end

      // Saturation on the MAXTAP=7 build, then walk back down.
      pulses(10, 1, 1);
      chk("satB_tap",   32'(ifb.o_tap),   32'd7);
      chk("satB_cflag", 32'(ifb.o_cflag), 32'd1);
      dir = DLY_DOWN;
      #1;
      chk("satB_cflag_down", 32'(ifb.o_cflag), 32'd0);
      pulses(8, 1, 1);
      chk("floorB_tap",   32'(ifb.o_tap),   32'd0);
      chk("floorB_cflag", 32'(ifb.o_cflag), 32'd1);

      // LOADN coinciding with a MOVE rising edge discards the step.
      loadn = 1'b0;
      tick("load");
      loadn = 1'b1;
      dir   = DLY_UP;
      pulses(3, 1, 1);
      chk("tap3", 32'(ifa.o_tap), 32'd3);
      move  = 1'b1;
      loadn = 1'b0;
      tick("load_vs_move");
      chk("load_wins", 32'(ifa.o_tap), 32'd0);
      loadn = 1'b1;
      tick("move_still_hi");
      chk("no_late_step", 32'(ifa.o_tap), 32'd0);
      move = 1'b0;
      tick("move_drop");

      // MOVE held high across reset release is not an edge.
      move = 1'b1;
      async_reset("rst_move_hi");
      repeat (3) tick("post_rst_move_hi");
      chk("held_move_ignored", 32'(ifa.o_tap), 32'd0);
      move = 1'b0;
      tick("rel_move");
      move = 1'b1;
      tick("rearm_move");
      chk("first_real_step", 32'(ifa.o_tap), 32'd1);
      move = 1'b0;
      tick("rel_move2");

      // Reset between edges with traffic at tap 5.
      pulses(4, 1, 1);
      for (int c = 0; c < 10; c++) begin
         pin = NP'($urandom);
         tick("traffic");
      end
      chk("pre_rst_tap5", 32'(ifa.o_tap), 32'd5);
      async_reset("midop_rst");
      chk("midop_tap0", 32'(ifa.o_tap), 32'd0);
      chk("midop_pin0", 32'(pin_a),     32'd0);
      pin = 4'b1010;
      tick("lat2_capture");
      pin = '0;
      tick("lat2_out");
      chk("lat2_pin", 32'(pin_a), 32'b1010);

      // Full range on the MAXTAP=127 build.
      dir = DLY_UP;
      pulses(130, 1, 1);
      chk("satA_tap",   32'(ifa.o_tap),   32'd127);
      chk("satA_cflag", 32'(ifa.o_cflag), 32'd1);
      dir = DLY_DOWN;
      pulses(130, 1, 1);
      chk("floorA_tap", 32'(ifa.o_tap), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         pin = NP'($urandom);
         if ($urandom_range(0, 2) == 0) move = ~move;
         if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
         loadn = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
